// File: rtl/fd_pkg.sv
// Shared types and constants for the round scoring stage.
package fd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ARMED = 3'd2,
    JUDGE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] RT_INIT        = 4'd12;
  localparam logic [3:0] RT_MIN         = 4'd4;
  localparam logic [1:0] LIVES_INIT     = 2'd3;
  localparam logic [2:0] HITS_PER_LEVEL = 3'd5;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD incrementer that saturates at 99.
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'h00;
    end else if (inc && (count != 8'h99)) begin
      if (count[3:0] == 4'd9) begin
        count[3:0] <= 4'd0;
        count[7:4] <= count[7:4] + 4'd1;
      end else begin
        count[3:0] <= count[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/round_judge.sv
// Judges key presses collected over each timer window and keeps score, lives
// and the window length. hit/miss are single-cycle registered pulses, no handshake.
module round_judge
  import fd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       gameState,
  input  logic       roundWindow,
  input  logic [3:0] target,
  input  logic [3:0] keys,
  output logic [3:0] roundTime,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       hit,
  output logic       miss,
  output logic       gameOver,
  output state_t     state_dbg
);

  state_t      state, state_next;
  logic        win_d;
  logic [3:0]  cap, tgt;
  logic [2:0]  level;
  logic        rise, fall;
  logic        init_regs, arm, accumulate, judge_en, apply;

  assign rise      = roundWindow & ~win_d;
  assign fall      = ~roundWindow & win_d;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    init_regs  = 1'b0;
    arm        = 1'b0;
    accumulate = 1'b0;
    judge_en   = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: if (gameState) state_next = WAIT;
      WAIT: begin
        if (!gameState) state_next = IDLE;
        else if (rise) begin
          state_next = ARMED;
          arm        = 1'b1;
        end
      end
      ARMED: begin
        if (!gameState) state_next = IDLE;
        else if (fall) begin
          state_next = JUDGE;
          judge_en   = 1'b1;
        end else if (roundWindow) accumulate = 1'b1;
      end
      // The verdict registered at the fall is applied here; a rise arriving
      // in this cycle re-arms directly so that window is not lost.
      JUDGE: begin
        if (!gameState) state_next = IDLE;
        else begin
          apply = 1'b1;
          if (miss && (lives == 2'd1)) state_next = OVER;
          else if (rise) begin
            state_next = ARMED;
            arm        = 1'b1;
          end else state_next = WAIT;
        end
      end
      OVER: begin
        if (!gameState) begin
          state_next = IDLE;
          init_regs  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_d     <= 1'b0;
      cap       <= 4'd0;
      tgt       <= 4'd0;
      level     <= 3'd0;
      lives     <= LIVES_INIT;
      roundTime <= RT_INIT;
      hit       <= 1'b0;
      miss      <= 1'b0;
      gameOver  <= 1'b0;
    end else begin
      win_d <= roundWindow;
      hit   <= judge_en & (cap == tgt);
      miss  <= judge_en & (cap != tgt);
      if (arm) begin
        tgt <= target;
        cap <= keys;
      end else if (accumulate) begin
        cap <= cap | keys;
      end
      if (init_regs) begin
        lives     <= LIVES_INIT;
        roundTime <= RT_INIT;
        level     <= 3'd0;
        gameOver  <= 1'b0;
      end
      if (apply) begin
        if (hit) begin
          if (level == HITS_PER_LEVEL - 3'd1) begin
            level <= 3'd0;
            if (roundTime != RT_MIN) roundTime <= roundTime - 4'd1;
          end else begin
            level <= level + 3'd1;
          end
        end else begin
          level <= 3'd0;
          lives <= lives - 2'd1;
          if (lives == 2'd1) gameOver <= 1'b1;
        end
      end
    end
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clear (init_regs),
    .inc   (apply & hit),
    .count (score)
  );

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge: driver tasks push expected verdicts and
// post-update values; a monitor pops them whenever a hit/miss pulse appears.
module tb_round_judge;
  import fd_pkg::*;

  logic       clk = 1'b0;
  logic       reset, gameState, roundWindow;
  logic [3:0] target, keys;
  logic [3:0] roundTime;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit, miss, gameOver;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // {hit, miss, score, lives, roundTime, gameOver}
  logic [16:0] exp_q[$];

  int m_score = 0;
  int m_lives = 3;
  int m_rt    = 12;
  int m_level = 0;

  round_judge dut (
    .clk         (clk),
    .reset       (reset),
    .gameState   (gameState),
    .roundWindow (roundWindow),
    .target      (target),
    .keys        (keys),
    .roundTime   (roundTime),
    .score       (score),
    .lives       (lives),
    .hit         (hit),
    .miss        (miss),
    .gameOver    (gameOver),
    .state_dbg   (state_dbg)
  );

  // clock / timeout
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, required end before 100000 ns");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0;
    m_lives = 3;
    m_rt    = 12;
    m_level = 0;
  endtask

  // One window: two open cycles with keys k0 then k1, then the fall cycle
  // (keys there must be ignored), then the JUDGE cycle.
  task automatic do_round(input logic [3:0] t, input logic [3:0] k0, input logic [3:0] k1);
    logic is_hit;
    is_hit = ((k0 | k1) == t);
    if (is_hit) begin
      if (m_score < 99) m_score++;
      m_level++;
      if (m_level == 5) begin
        m_level = 0;
        if (m_rt > 4) m_rt--;
      end
    end else begin
      m_level = 0;
      m_lives--;
    end
    exp_q.push_back({is_hit, ~is_hit, to_bcd(m_score), 2'(m_lives), 4'(m_rt),
                     (m_lives == 0)});
    target      = t;
    roundWindow = 1'b1;
    keys        = k0;
    @(posedge clk);
    #1;
    keys   = k1;
    target = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    roundWindow = 1'b0;
    keys        = 4'b1000;
    @(posedge clk);
    #1;
    keys = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (hit || miss) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got hit=%0b miss=%0b, required no pulse at %0t",
                   hit, miss, $time);
        end else begin
          e = exp_q.pop_front();
          check("hit", hit, e[16]);
          check("miss", miss, e[15]);
          @(negedge clk);
          check("score", score, e[14:7]);
          check("lives", lives, e[6:5]);
          check("roundTime", roundTime, e[4:1]);
          check("gameOver", gameOver, e[0]);
          check("pulse_width", hit | miss, 0);
        end
      end
    end
  end

  localparam int NPAT = 8;
  logic [3:0] pat [NPAT] = '{4'b0101, 4'b0000, 4'b1111, 4'b1000,
                             4'b0011, 4'b0110, 4'b0001, 4'b1010};

  initial begin
    reset       = 1'b1;
    gameState   = 1'b0;
    roundWindow = 1'b0;
    target      = 4'd0;
    keys        = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_state", int'(state_dbg), int'(IDLE));
    check("rst_score", score, 8'h00);
    check("rst_lives", lives, 3);
    check("rst_roundTime", roundTime, 12);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_gameOver", gameOver, 0);

    gameState = 1'b1;
    @(posedge clk);
    #1;
    check("start_state", int'(state_dbg), int'(WAIT));

    do_round(4'b0101, 4'b0101, 4'b0101);
    do_round(4'b0101, 4'b0111, 4'b0000);
    do_round(4'b0000, 4'b0010, 4'b0000);
    do_round(4'b1010, 4'b0010, 4'b0000);
    check("over_state", int'(state_dbg), int'(OVER));
    @(posedge clk);
    #1;
    check("over_hold", int'(state_dbg), int'(OVER));

    gameState = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("newgame_state", int'(state_dbg), int'(IDLE));
    check("newgame_lives", lives, 3);
    check("newgame_score", score, 8'h00);
    check("newgame_roundTime", roundTime, 12);
    check("newgame_gameOver", gameOver, 0);

    gameState = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 101; i++) begin
      if (i % 2 == 0) do_round(pat[i % NPAT], pat[i % NPAT] & 4'b0011, pat[i % NPAT] & 4'b1100);
      else            do_round(pat[i % NPAT], pat[i % NPAT], 4'b0000);
    end

    // game stops mid-window: no verdict, values held
    target      = 4'b0011;
    roundWindow = 1'b1;
    keys        = 4'b0011;
    @(posedge clk);
    #1;
    check("drop_armed", int'(state_dbg), int'(ARMED));
    gameState = 1'b0;
    @(posedge clk);
    #1;
    check("drop_state", int'(state_dbg), int'(IDLE));
    roundWindow = 1'b0;
    keys        = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("drop_score", score, 8'h99);
    check("drop_lives", lives, 3);
    check("drop_roundTime", roundTime, 4);

    // reset in the middle of a window
    gameState = 1'b1;
    @(posedge clk);
    #1;
    roundWindow = 1'b1;
    keys        = 4'b0101;
    @(posedge clk);
    #1;
    check("midrst_armed", int'(state_dbg), int'(ARMED));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", int'(state_dbg), int'(IDLE));
    check("midrst_score", score, 8'h00);
    check("midrst_lives", lives, 3);
    check("midrst_roundTime", roundTime, 12);
    check("midrst_pulses", hit | miss, 0);
    check("midrst_gameOver", gameOver, 0);
    reset       = 1'b0;
    roundWindow = 1'b0;
    keys        = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_judge.md
# round_judge

Scoring stage directly downstream of the round timer. It watches the timer's window phase (`roundWindow`, high while the player may press) and accumulates the player's key presses over each window. When the window closes it judges the collected keys against the target pattern latched at window open, then updates a two-digit BCD score and a lives counter. It also produces `roundTime`, which feeds back into the timer and shortens the window as the player keeps hitting.

## Interface
- `LIVES_INIT`, 3: lives loaded at reset and at each new game.
- `RT_INIT`, 4'd12: `roundTime` value at reset and at each new game.
- `RT_MIN`, 4'd4: floor for `roundTime`.
- `HITS_PER_LEVEL`, 5: number of consecutive hit judgements that shortens `roundTime` by 1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `gameState`, in, 1: 1 = game running.
- `roundWindow`, in, 1: timer phase; 1 = input window open.
- `target`, in, 4: required key pattern; sampled at window open.
- `keys`, in, 4: player buttons, level-sensitive, already synchronized and debounced.
- `roundTime`, out, 4: window length to the timer.
- `score`, out, 8: BCD tens in [7:4], BCD ones in [3:0].
- `lives`, out, 2: lives remaining.
- `hit`, out, 1: one-cycle pulse on a correct round.
- `miss`, out, 1: one-cycle pulse on a failed round.
- `gameOver`, out, 1: level; high while in OVER.

## Operation
- `winD` registers `roundWindow` every cycle.
  - Rise: `roundWindow`=1 and `winD`=0.
  - Fall: `roundWindow`=0 and `winD`=1.
- States:
  - IDLE: wait for `gameState`=1. On entry from reset or OVER, `score`, `lives`, `roundTime` and the level counter take their init values.
  - WAIT: wait for a rise.
  - ARMED: collecting key presses.
  - JUDGE: one cycle.
  - OVER: wait for `gameState`=0, then go to IDLE.
- On a rise (from WAIT):
  - `tgt` <= `target`.
  - `cap` <= `keys`; `keys` pressed in the rise cycle count.
  - Go to ARMED.
- ARMED, each cycle with `roundWindow`=1: `cap` <= `cap` | `keys`.
- ARMED, on a fall: go to JUDGE. `keys` in the fall cycle are ignored.
- JUDGE:
  - Hit iff `cap` == `tgt`. A target of 0 is a rest round, and only "no key pressed" is a hit.
  - Hit:
    - `hit`=1.
    - `score` += 1 in BCD, saturating at 0x99.
    - Level counter += 1. When it reaches `HITS_PER_LEVEL`: clear it, and `roundTime` -= 1 unless it is already `RT_MIN`.
  - Miss:
    - `miss`=1.
    - Level counter cleared.
    - `lives` -= 1.
    - If `lives` was 1, go to OVER; otherwise go to WAIT.
- `gameState`=0 in WAIT, ARMED or JUDGE:
  - Go to IDLE with no judgement and no pulse.
  - `score`, `lives` and `roundTime` hold their values; they are re-initialized only on leaving OVER or on reset.
- A rise seen in JUDGE is not lost: the JUDGE exit goes straight to ARMED with `cap` and `tgt` loaded as for a rise. This cannot occur with the current timer; it is required for robustness.
- A fall seen in WAIT is ignored. This covers a window that was already open when `gameState` went high.

## Timing
- Reset values:
  - State: IDLE.
  - `score`=0x00.
  - `lives`=`LIVES_INIT`.
  - `roundTime`=`RT_INIT`.
  - `hit`, `miss`, `gameOver`=0.
  - `winD`=0, `cap`=0, `tgt`=0, level counter=0.
- `reset` takes priority over every other input on the same edge.
- All outputs are registered.
- `hit`/`miss` are high for exactly the one cycle after the edge at which the fall is sampled.
- `score`, `lives` and `roundTime` change at the edge that ends JUDGE. This is 2 edges after the fall is sampled.
- `gameOver` rises on the same edge as the `lives`=0 update and stays high until the edge that leaves OVER.

## Structure
- Shared package (`fd_pkg`): state enum (IDLE, WAIT, ARMED, JUDGE, OVER) and constants `RT_INIT`, `RT_MIN`, `LIVES_INIT`, `HITS_PER_LEVEL`.
- One sub-module: `bcd_counter2`, a two-digit saturating BCD incrementer with inputs clk, reset, clear, inc and an 8-bit output. The score uses it.

## Test plan
- Reset, `gameState`=1, `target`=4'b0101, `keys`=0101 during the window -> `hit` pulse 1 cycle; `score`=0x01 two edges after the fall; `lives`=3.
- `target`=0101 with `keys`=0111 for one window cycle -> `miss`; `lives`=2; `score` unchanged.
- Three consecutive misses -> `lives`=0, `gameOver`=1. `gameState`=0 -> IDLE with `lives`=3, `score`=0x00, `roundTime`=12.
- 5 hits -> `roundTime`=11; 40 hits -> `roundTime`=4, and it stays 4 after 5 more hits.
- Preload `score`=0x98 with 2 more hits -> 0x99 and stays 0x99. Check 0x09 -> 0x10 on one hit.
- `gameState` drops mid-ARMED -> no pulse, state IDLE, `score`/`lives` held. Assert `reset` mid-window -> all reset values on the next edge.
